// File: rtl/ex_stage.sv
`default_nettype none
// ============================================================================
//  Module      : ex_stage
//  Description : Execute stage of the 5-stage RV32I pipeline. Contains a
//                combinational 32-bit ALU with zero flag, combinational
//                next-PC selection for branches and jumps, and the EX/MEM
//                pipeline register feeding the MEM stage.
//
//  Ports       : clk, reset          - clock, synchronous active-high reset
//                alu_sel, op_a, op_b - ALU operation and operands
//                rs2_data            - store data
//                instruction, pc     - instruction in EX and its PC
//                pc_target           - precomputed JAL/JALR target
//                branch_en, jumpl_en - branch / jump qualifiers
//                mem_to_reg, mem_read, mem_write - memory control bits
//                alu_out, zeroflag, pc_next      - combinational results
//                alu_out_n, rs2_data_n, mem_*_n2 - EX/MEM register outputs
//
//  Options     : EX_STAGE_MUL_EN - when defined, alu_sel 4'b1010 computes
//                the low 32 bits of op_a*op_b; otherwise it yields 0 and no
//                multiplier is built.
//
//  Revision    : 1.0 - initial release
// ============================================================================
module ex_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [3:0]      alu_sel,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [31:0]     instruction,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] pc_target,
    input  logic            branch_en,
    input  logic            jumpl_en,
    input  logic            mem_to_reg,
    input  logic            mem_read,
    input  logic            mem_write,
    output logic [XLEN-1:0] alu_out,
    output logic            zeroflag,
    output logic [XLEN-1:0] pc_next,
    output logic [XLEN-1:0] alu_out_n,
    output logic [XLEN-1:0] rs2_data_n,
    output logic            mem_to_reg_n2,
    output logic            mem_read_n2,
    output logic            mem_write_n2
);

    // ALU operation codes
    localparam logic [3:0] c_op_add  = 4'b0000;
    localparam logic [3:0] c_op_sub  = 4'b0001;
    localparam logic [3:0] c_op_and  = 4'b0010;
    localparam logic [3:0] c_op_or   = 4'b0011;
    localparam logic [3:0] c_op_xor  = 4'b0100;
    localparam logic [3:0] c_op_sll  = 4'b0101;
    localparam logic [3:0] c_op_srl  = 4'b0110;
    localparam logic [3:0] c_op_sra  = 4'b0111;
    localparam logic [3:0] c_op_slt  = 4'b1000;
    localparam logic [3:0] c_op_sltu = 4'b1001;
`ifdef EX_STAGE_MUL_EN
    localparam logic [3:0] c_op_mul  = 4'b1010;
`endif

    localparam logic [XLEN-1:0] c_pc_step = XLEN'(4);

    logic [4:0]      w_shamt;
    logic [XLEN-1:0] w_alu;
    logic [2:0]      w_funct3;
    logic            w_taken;
    logic [XLEN-1:0] w_b_imm;
    logic            w_unused_instr;

    // Only the low five bits of operand B are a legal RV32 shift amount.
    assign w_shamt = op_b[4:0];

    // ------------------------------------------------------------------
    // ALU
    // ------------------------------------------------------------------
    always_comb begin
        w_alu = '0;
        case (alu_sel)
            c_op_add:  w_alu = op_a + op_b;
            c_op_sub:  w_alu = op_a - op_b;
            c_op_and:  w_alu = op_a & op_b;
            c_op_or:   w_alu = op_a | op_b;
            c_op_xor:  w_alu = op_a ^ op_b;
            c_op_sll:  w_alu = op_a << w_shamt;
            c_op_srl:  w_alu = op_a >> w_shamt;
            c_op_sra:  w_alu = $unsigned($signed(op_a) >>> w_shamt);
            c_op_slt:  w_alu = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            c_op_sltu: w_alu = {{(XLEN-1){1'b0}}, (op_a < op_b)};
`ifdef EX_STAGE_MUL_EN
            c_op_mul:  w_alu = op_a * op_b;
`else
            // 4'b1010 falls through to the zero default: no multiplier.
`endif
            default:   w_alu = '0;
        endcase
    end

    assign alu_out  = w_alu;
    assign zeroflag = (w_alu == '0);

    // ------------------------------------------------------------------
    // Branch resolution and next PC
    // ------------------------------------------------------------------
    // The ID stage programs SUB for BEQ/BNE and SLT/SLTU for the ordered
    // compares, so every condition reduces to testing the zero flag:
    // SLT/SLTU give a nonzero result exactly when "less than" holds.
    assign w_funct3 = instruction[14:12];

    always_comb begin
        w_taken = 1'b0;
        case (w_funct3)
            3'b000:  w_taken = zeroflag;   // BEQ
            3'b001:  w_taken = ~zeroflag;  // BNE
            3'b100:  w_taken = ~zeroflag;  // BLT
            3'b101:  w_taken = zeroflag;   // BGE
            3'b110:  w_taken = ~zeroflag;  // BLTU
            3'b111:  w_taken = zeroflag;   // BGEU
            default: w_taken = 1'b0;       // reserved encodings
        endcase
    end

    // B-type immediate, sign-extended, bit 0 always zero.
    assign w_b_imm = {{(XLEN-12){instruction[31]}}, instruction[7],
                      instruction[30:25], instruction[11:8], 1'b0};

    // Jumps win over branches; otherwise fall through sequentially.
    always_comb begin
        pc_next = pc + c_pc_step;
        if (jumpl_en) begin
            pc_next = pc_target;
        end else if (branch_en && w_taken) begin
            pc_next = pc + w_b_imm;
        end
    end

    // Register, rd and opcode fields are decoded upstream.
    assign w_unused_instr = ^{instruction[24:15], instruction[6:0]};

    // ------------------------------------------------------------------
    // EX/MEM pipeline register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            alu_out_n     <= '0;
            rs2_data_n    <= '0;
            mem_to_reg_n2 <= 1'b0;
            mem_read_n2   <= 1'b0;
            mem_write_n2  <= 1'b0;
        end else begin
            alu_out_n     <= w_alu;
            rs2_data_n    <= rs2_data;
            mem_to_reg_n2 <= mem_to_reg;
            mem_read_n2   <= mem_read;
            mem_write_n2  <= mem_write;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ex_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ex_stage
//  Description : Self-checking bench for ex_stage. Directed steps from the
//                test plan followed by random vectors checked against a
//                behavioural model of the ALU, branch rules and EX/MEM
//                register.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  alu_sel;
    logic [31:0] op_a, op_b, rs2_data, instruction, pc, pc_target;
    logic        branch_en, jumpl_en, mem_to_reg, mem_read, mem_write;
    logic [31:0] alu_out, pc_next, alu_out_n, rs2_data_n;
    logic        zeroflag, mem_to_reg_n2, mem_read_n2, mem_write_n2;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    ex_stage #(.XLEN(32)) dut (
        .clk           (clk),
        .reset         (reset),
        .alu_sel       (alu_sel),
        .op_a          (op_a),
        .op_b          (op_b),
        .rs2_data      (rs2_data),
        .instruction   (instruction),
        .pc            (pc),
        .pc_target     (pc_target),
        .branch_en     (branch_en),
        .jumpl_en      (jumpl_en),
        .mem_to_reg    (mem_to_reg),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .alu_out       (alu_out),
        .zeroflag      (zeroflag),
        .pc_next       (pc_next),
        .alu_out_n     (alu_out_n),
        .rs2_data_n    (rs2_data_n),
        .mem_to_reg_n2 (mem_to_reg_n2),
        .mem_read_n2   (mem_read_n2),
        .mem_write_n2  (mem_write_n2)
    );

    // ---------------- reference model ----------------
    function automatic logic [31:0] m_alu(input logic [3:0] sel,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        int unsigned sh;
        sh = b % 32;
        case (sel)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return a & b;
            4'd3:  return a | b;
            4'd4:  return a ^ b;
            4'd5:  return a << sh;
            4'd6:  return a >> sh;
            4'd7:  return a[31] ? ~((~a) >> sh) : (a >> sh);
            4'd8:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd9:  return (a < b) ? 32'd1 : 32'd0;
`ifdef EX_STAGE_MUL_EN
            4'd10: return a * b;
`endif
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] m_pc(input logic [31:0] instr,
                                         input logic [31:0] pcv,
                                         input logic [31:0] tgt,
                                         input logic        br,
                                         input logic        jl,
                                         input logic [31:0] res);
        logic [12:0] b13;
        logic [2:0]  f3;
        logic        take;
        int          off;
        b13  = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
        off  = int'($signed(b13));
        f3   = instr[14:12];
        take = 1'b0;
        if (f3 == 3'd0 || f3 == 3'd5 || f3 == 3'd7) take = (res == 32'd0);
        if (f3 == 3'd1 || f3 == 3'd4 || f3 == 3'd6) take = (res != 32'd0);
        if (jl)             return tgt;
        else if (br && take) return pcv + off;
        else                return pcv + 32'd4;
    endfunction

    // ---------------- checking helpers ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic [3:0] sel,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] rs2, input logic [31:0] ins,
                         input logic [31:0] pcv, input logic [31:0] tgt,
                         input logic br, input logic jl,
                         input logic m2r, input logic mr, input logic mw);
        reset = rst; alu_sel = sel; op_a = a; op_b = b; rs2_data = rs2;
        instruction = ins; pc = pcv; pc_target = tgt; branch_en = br;
        jumpl_en = jl; mem_to_reg = m2r; mem_read = mr; mem_write = mw;
        #1;
    endtask

    // Check combinational outputs against the model, clock once, then
    // check the EX/MEM register against what it should have captured.
    task automatic cycle(input string tag);
        logic [31:0] e_alu, e_pc;
        logic        rst_at_edge;
        #1;
        e_alu = m_alu(alu_sel, op_a, op_b);
        e_pc  = m_pc(instruction, pc, pc_target, branch_en, jumpl_en, e_alu);
        chk({tag, ".alu_out"}, alu_out, e_alu);
        chk({tag, ".zeroflag"}, {31'd0, zeroflag}, {31'd0, (e_alu == 32'd0)});
        chk({tag, ".pc_next"}, pc_next, e_pc);
        rst_at_edge = reset;
        @(posedge clk);
        #1;
        chk({tag, ".alu_out_n"}, alu_out_n, rst_at_edge ? 32'd0 : e_alu);
        chk({tag, ".rs2_data_n"}, rs2_data_n, rst_at_edge ? 32'd0 : rs2_data);
        chk({tag, ".mem_to_reg_n2"}, {31'd0, mem_to_reg_n2}, {31'd0, mem_to_reg & ~rst_at_edge});
        chk({tag, ".mem_read_n2"}, {31'd0, mem_read_n2}, {31'd0, mem_read & ~rst_at_edge});
        chk({tag, ".mem_write_n2"}, {31'd0, mem_write_n2}, {31'd0, mem_write & ~rst_at_edge});
    endtask

    localparam logic [31:0] c_beq_p8 = 32'h0000_0463; // BEQ, offset +8
    localparam logic [31:0] c_blt_p8 = 32'h0000_4463; // BLT, offset +8

    initial begin
        // Reset held over an edge with nonzero inputs.
        drive(1'b1, 4'd0, 32'd7, 32'd9, 32'hDEAD_BEEF, c_beq_p8, 32'h100, 32'h400, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        chk("rst.alu_out_comb", alu_out, 32'd16);
        cycle("rst");
        chk("rst.alu_out_n_zero", alu_out_n, 32'd0);
        // Release: next edge captures.
        drive(1'b0, 4'd0, 32'd7, 32'd9, 32'hDEAD_BEEF, c_beq_p8, 32'h100, 32'h400, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        cycle("release");
        chk("release.rs2_data_n", rs2_data_n, 32'hDEAD_BEEF);

        // ADD
        drive(1'b0, 4'd0, 32'd10, 32'd20, 32'd20, 32'd0, 32'h100, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("add.value", alu_out, 32'd30);
        cycle("add");
        chk("add.alu_out_n_value", alu_out_n, 32'd30);

        // Load address
        drive(1'b0, 4'd0, 32'd100, 32'd12, 32'd20, 32'd0, 32'h100, 32'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        cycle("load");
        chk("load.alu_out_n_value", alu_out_n, 32'd112);
        chk("load.mem_read_n2_value", {31'd0, mem_read_n2}, 32'd1);

        // Store
        drive(1'b0, 4'd0, 32'd200, 32'd16, 32'd55, 32'd0, 32'h100, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        cycle("store");
        chk("store.alu_out_n_value", alu_out_n, 32'd216);
        chk("store.rs2_data_n_value", rs2_data_n, 32'd55);

        // Branches from pc=0x100, offset +8
        drive(1'b0, 4'd1, 32'd5, 32'd5, 32'd0, c_beq_p8, 32'h100, 32'h400, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("beq_taken.zeroflag", {31'd0, zeroflag}, 32'd1);
        chk("beq_taken.pc_next", pc_next, 32'h108);
        cycle("beq_taken");
        drive(1'b0, 4'd1, 32'd5, 32'd4, 32'd0, c_beq_p8, 32'h100, 32'h400, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("beq_not.pc_next", pc_next, 32'h104);
        cycle("beq_not");
        drive(1'b0, 4'd8, 32'hFFFF_FFFD, 32'd2, 32'd0, c_blt_p8, 32'h100, 32'h400, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("blt_taken.pc_next", pc_next, 32'h108);
        cycle("blt_taken");
        drive(1'b0, 4'd1, 32'd5, 32'd5, 32'd0, c_beq_p8, 32'h100, 32'h400, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("jump_prio.pc_next", pc_next, 32'h400);
        cycle("jump_prio");

        // ALU sweep
        drive(1'b0, 4'd7, 32'h8000_0000, 32'd4, 32'd0, 32'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("sra.value", alu_out, 32'hF800_0000);
        cycle("sra");
        drive(1'b0, 4'd9, 32'd1, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("sltu.value", alu_out, 32'd1);
        cycle("sltu");
        drive(1'b0, 4'd0, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("add_wrap.value", alu_out, 32'd0);
        chk("add_wrap.zeroflag", {31'd0, zeroflag}, 32'd1);
        cycle("add_wrap");
        drive(1'b0, 4'd15, 32'd123, 32'd456, 32'd0, 32'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("code15.value", alu_out, 32'd0);
        cycle("code15");
        drive(1'b0, 4'd10, 32'd3, 32'd7, 32'd0, 32'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef EX_STAGE_MUL_EN
        chk("code10.value", alu_out, 32'd21);
`else
        chk("code10.value", alu_out, 32'd0);
`endif
        cycle("code10");

        // Reset mid-operation discards the in-flight store.
        drive(1'b1, 4'd0, 32'd200, 32'd16, 32'd55, 32'd0, 32'h100, 32'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        chk("midrst.pc_next_comb", pc_next, 32'h104);
        cycle("midrst");

        // Random vectors
        for (int i = 0; i < 300; i++) begin
            logic [31:0] a, b;
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            if ($urandom_range(0, 3) == 0) b = b % 32;
            drive(($urandom_range(0, 15) == 0), 4'($urandom_range(0, 15)), a, b,
                  $urandom, $urandom, $urandom, $urandom,
                  1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)));
            cycle("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Safety net so the run can never hang.
    initial begin
        #200000;
        $display("FAIL timeout: observed no end of stimulus, expected completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
